rf_wport_arbiter: RTL and testbench
===================================

Name: rf_wport_arbiter

Overview:
- Shares the single write port of the 2R1W 32x32 register file between two writeback requesters.
  - req0: single-cycle ALU pipeline writeback.
  - req1: multi-cycle unit (load/mul) writeback.
- Round-robin arbitration, registered write stage driving the register file's wen/waddr/wdata.
- Pending-write scoreboard that issue logic queries for RAW hazards.

Parameters:
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a write.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req0_addr  in  ADDR_WIDTH  destination register.
- req0_data  in  DATA_WIDTH  write data.
- req1_valid, req1_ready, req1_addr, req1_data: same as req0, for requester 1.
- rsv_valid  in  1  issue stage reserves a destination register.
- rsv_addr  in  ADDR_WIDTH  register being reserved.
- q_addr1, q_addr2  in  ADDR_WIDTH  hazard query addresses (register file read addresses).
- q_busy1, q_busy2  out  1  queried register has a pending write.
- rf_wen  out  1  to register file wen.
- rf_waddr  out  ADDR_WIDTH  to register file waddr.
- rf_wdata  out  DATA_WIDTH  to register file wdata.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - All busy bits=0.
  - Round-robin pointer last_grant=1, so req0 has priority first.
  - req*_ready and q_busy* are combinational and therefore 0 while in reset.
- Arbitration is combinational:
  - Only one requester valid: it is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - readyN = grant to N.
  - Handshake = validN && readyN; at most one per cycle.
  - last_grant updates to the granted id on each handshake only.
- Requester rules:
  - A requester holds valid, addr and data stable until its handshake.
  - A requester may not drop valid before its handshake.
- Write stage:
  - A handshake at cycle T produces rf_wen=1 with the latched addr/data during cycle T+1; the register file commits at the end of T+1.
  - No handshake: rf_wen=0 next cycle; rf_waddr/rf_wdata hold their last values.
  - The write stage never stalls, so throughput is 1 write per cycle.
- Register 0:
  - A handshake with addr==0 completes normally, but rf_wen stays 0 in T+1.
  - rsv_addr==0 never sets a busy bit.
  - q_busy for address 0 is always 0.
- Scoreboard:
  - busy[a] sets at the edge where rsv_valid && rsv_addr==a (a!=0).
  - busy[a] clears at the edge ending a cycle with rf_wen && rf_waddr==a.
  - Set and clear of the same register on the same edge: set wins (a newer producer was issued).
  - Reservation of an already-busy register: the bit stays set. No per-register count; issue logic stalls on busy before re-reserving.
- Queries:
  - q_busyN = busy[q_addrN], combinational.
  - Without the bypass feature, busy remains 1 during the rf_wen cycle.
- Mid-operation reset:
  - A latched write is dropped: rf_wen=0 immediately.
  - All reservations are lost.
  - Requesters must re-present any outstanding writes after reset.

Optional Feature:
- Macro: RF_WPORT_BYPASS_EN.
- Defined:
  - Adds outputs q_fwd1, q_fwd2 (1 bit) and q_fwd_data (DATA_WIDTH).
  - q_fwdN = rf_wen && rf_waddr==q_addrN && q_addrN!=0.
  - q_fwd_data = rf_wdata.
  - q_busyN is masked to 0 when q_fwdN=1; the consumer muxes q_fwd_data over rdataN, saving one stall cycle.
- Undefined: none of these ports exist; q_busy behaves as described in Behaviour.

Decomposition:
- Package rf_arb_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH and NUM_REGS constants.
  - Requester-id typedef (1 bit: REQ_ALU=0, REQ_MC=1).
  - Write-request struct {addr, data}.
- One sub-module, rf_scoreboard:
  - NUM_REGS busy bitmap with set/clear ports and two query ports.
  - Owns the x0 masking and the set-wins rule.

Test Plan:
1. Reset then req0 valid, addr=5, data=0xDEADBEEF -> req0_ready=1 same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; the following cycle rf_wen=0.
2. Both requesters valid continuously (req0 addr 1..4, req1 addr 9..12) -> grants alternate req0, req1, req0, req1; rf_waddr sequence 1, 9, 2, 10, ...; no lost or duplicate writes.
3. req1 valid addr=0 data=0x1234 -> req1_ready=1, rf_wen stays 0; a subsequent rsv_addr=0 -> q_busy with q_addr1=0 stays 0.
4. rsv addr=7 at T0; req0 handshake addr=7 at T3 -> q_busy1 (q_addr1=7) =1 through T4, 0 from T5. With RF_WPORT_BYPASS_EN: q_fwd1=1 and q_busy1=0 at T4, with q_fwd_data = the written data.
5. rsv addr=8 on the same edge as the rf write of addr=8 -> busy[8] remains 1.
6. Handshake at T, rst_n low during T+1 -> rf_wen drops to 0 asynchronously, all busy bits clear; after release, req0 has priority when both requesters are valid.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// The RF_WPORT_BYPASS_EN build option is handled in rf_wport_arbiter.
package rf_arb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MC  = 1'b1
  } req_id_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wreq_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write bitmap: one busy bit per register, set by issue, cleared by writeback.
// Register 0 never reads as busy; a set on the same edge as a clear wins.
module rf_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_valid,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_valid,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] q_addr1,
  input  logic [ADDR_WIDTH-1:0] q_addr2,
  output logic                  q_busy1,
  output logic                  q_busy2
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // NOTE: starting from busy_q makes every bit assigned on every path, so no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid) busy_d[clr_addr] = 1'b0;
    // Applied after the clear: a newer producer issued on this edge keeps the bit set.
    if (set_valid) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: the bitmap is plain flops, not RAM, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      busy_q <= busy_d;
    end
  end

  assign q_busy1 = busy_q[q_addr1];
  assign q_busy2 = busy_q[q_addr2];

endmodule

// File: rtl/rf_wport_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and the
// multi-cycle unit, with a registered write stage and a RAW scoreboard. RF_WPORT_BYPASS_EN adds forwarding.
module rf_wport_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  rsv_valid,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  input  logic [ADDR_WIDTH-1:0] q_addr1,
  input  logic [ADDR_WIDTH-1:0] q_addr2,
  output logic                  q_busy1,
  output logic                  q_busy2,
`ifdef RF_WPORT_BYPASS_EN
  output logic                  q_fwd1,
  output logic                  q_fwd2,
  output logic [DATA_WIDTH-1:0] q_fwd_data,
`endif
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  import rf_arb_pkg::*;

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  req_id_t               last_grant_q, last_grant_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic                  grant0, grant1, hs;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sb_busy1, sb_busy2;

  always_comb begin
    // With both valid, the requester that did not win last time goes next.
    grant0   = req0_valid && (!req1_valid || last_grant_q == REQ_MC);
    grant1   = req1_valid && !grant0;
    hs       = rst_n && (grant0 || grant1);
    sel_addr = grant1 ? req1_addr : req0_addr;
    sel_data = grant1 ? req1_data : req0_data;

    last_grant_d = last_grant_q;
    rf_wen_d     = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    if (hs) begin
      last_grant_d = grant1 ? REQ_MC : REQ_ALU;
      // Writes to x0 complete the handshake but never reach the register file.
      rf_wen_d     = (sel_addr != '0);
      rf_waddr_d   = sel_addr;
      rf_wdata_d   = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= REQ_MC;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign req0_ready = rst_n && grant0;
  assign req1_ready = rst_n && grant1;
  assign rf_wen     = rf_wen_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_valid (rsv_valid),
    .set_addr  (rsv_addr),
    .clr_valid (rf_wen_q),
    .clr_addr  (rf_waddr_q),
    .q_addr1   (q_addr1),
    .q_addr2   (q_addr2),
    .q_busy1   (sb_busy1),
    .q_busy2   (sb_busy2)
  );

`ifdef RF_WPORT_BYPASS_EN
  // A register being written this cycle is served from the write stage instead of stalling.
  assign q_fwd1     = rf_wen_q && (rf_waddr_q == q_addr1) && (q_addr1 != '0);
  assign q_fwd2     = rf_wen_q && (rf_waddr_q == q_addr2) && (q_addr2 != '0);
  assign q_fwd_data = rf_wdata_q;
  assign q_busy1    = sb_busy1 && !q_fwd1;
  assign q_busy2    = sb_busy2 && !q_fwd2;
`else
  assign q_busy1    = sb_busy1;
  assign q_busy2    = sb_busy2;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: expected register-file writes are queued at each
// handshake and matched by a write-port monitor; hazard and reset behaviour checked inline.
module tb_rf_wport_arbiter;
  import rf_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, rsv_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr = '0, req1_addr = '0, rsv_addr = '0, q_addr1 = '0, q_addr2 = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        q_busy1, q_busy2, rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef RF_WPORT_BYPASS_EN
  logic        q_fwd1, q_fwd2;
  logic [31:0] q_fwd_data;
`endif

  int    n_checks = 0;
  int    n_fail   = 0;
  wreq_t exp_q[$];

  always #5 clk = ~clk;

  rf_wport_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .q_addr1    (q_addr1),
    .q_addr2    (q_addr2),
    .q_busy1    (q_busy1),
    .q_busy2    (q_busy2),
`ifdef RF_WPORT_BYPASS_EN
    .q_fwd1     (q_fwd1),
    .q_fwd2     (q_fwd2),
    .q_fwd_data (q_fwd_data),
`endif
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] addr, input logic [31:0] data);
    wreq_t w;
    w.addr = addr;
    w.data = data;
    exp_q.push_back(w);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsv_valid  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Write-port monitor: every rf_wen cycle must match the oldest queued write.
  always @(negedge clk) begin
    if (rst_n && rf_wen) begin
      wreq_t e;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {31'd0, rf_wen}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {27'd0, rf_waddr}, {27'd0, e.addr});
        check("wr_data", rf_wdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] a0 [4];
    logic [4:0] a1 [4];
    int i0, i1;
    logic exp_g0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_wen", {31'd0, rf_wen}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, req1_ready}, 32'd0);
    check("rst_busy1", {31'd0, q_busy1}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single write, one-cycle latency
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_ready0", {31'd0, req0_ready}, 32'd1);
    check("t1_ready1", {31'd0, req1_ready}, 32'd0);
    check("t1_wen_T", {31'd0, rf_wen}, 32'd0);
    push_exp(5'd5, 32'hDEADBEEF);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    check("t1_wen_T1", {31'd0, rf_wen}, 32'd1);
    check("t1_waddr", {27'd0, rf_waddr}, 32'd5);
    check("t1_wdata", rf_wdata, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    check("t1_wen_T2", {31'd0, rf_wen}, 32'd0);
    check("t1_waddr_hold", {27'd0, rf_waddr}, 32'd5);

    // 2: both valid continuously -> strict alternation starting with req0
    do_reset();
    a0 = '{5'd1, 5'd2, 5'd3, 5'd4};
    a1 = '{5'd9, 5'd10, 5'd11, 5'd12};
    i0 = 0;
    i1 = 0;
    for (int cyc = 0; cyc < 12 && (i0 < 4 || i1 < 4); cyc++) begin
      req0_valid = (i0 < 4);
      req1_valid = (i1 < 4);
      if (i0 < 4) begin req0_addr = a0[i0]; req0_data = 32'hA000_0000 + 32'(i0); end
      if (i1 < 4) begin req1_addr = a1[i1]; req1_data = 32'hB000_0000 + 32'(i1); end
      @(negedge clk);
      exp_g0 = (cyc % 2 == 0);
      check("t2_ready0", {31'd0, req0_ready}, {31'd0, exp_g0});
      check("t2_ready1", {31'd0, req1_ready}, {31'd0, !exp_g0});
      if (exp_g0) begin
        push_exp(a0[i0], 32'hA000_0000 + 32'(i0));
        i0++;
      end else begin
        push_exp(a1[i1], 32'hB000_0000 + 32'(i1));
        i1++;
      end
      next_cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("t2_all_granted", 32'(i0 + i1), 32'd8);
    next_cycle();
    next_cycle();
    check("t2_queue_drained", 32'(exp_q.size()), 32'd0);

    // 3: x0 write and x0 reservation have no effect
    do_reset();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
    @(negedge clk);
    check("t3_ready1", {31'd0, req1_ready}, 32'd1);
    next_cycle();
    req1_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 5'd0; q_addr1 = 5'd0;
    @(negedge clk);
    check("t3_wen", {31'd0, rf_wen}, 32'd0);
    next_cycle();
    rsv_valid = 1'b0;
    @(negedge clk);
    check("t3_busy_x0", {31'd0, q_busy1}, 32'd0);

    // 4: reserve x7 at T0, write x7 at T3
    do_reset();
    rsv_valid = 1'b1; rsv_addr = 5'd7; q_addr1 = 5'd7; q_addr2 = 5'd6;
    @(negedge clk);
    check("t4_busy_T0", {31'd0, q_busy1}, 32'd0);
    next_cycle();
    rsv_valid = 1'b0;
    @(negedge clk);
    check("t4_busy_T1", {31'd0, q_busy1}, 32'd1);
    check("t4_busy2_other", {31'd0, q_busy2}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("t4_busy_T2", {31'd0, q_busy1}, 32'd1);
    next_cycle();
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hCAFE_0007;
    @(negedge clk);
    check("t4_ready0_T3", {31'd0, req0_ready}, 32'd1);
    check("t4_busy_T3", {31'd0, q_busy1}, 32'd1);
    push_exp(5'd7, 32'hCAFE_0007);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    check("t4_wen_T4", {31'd0, rf_wen}, 32'd1);
`ifdef RF_WPORT_BYPASS_EN
    check("t4_busy_T4", {31'd0, q_busy1}, 32'd0);
    check("t4_fwd1_T4", {31'd0, q_fwd1}, 32'd1);
    check("t4_fwd2_T4", {31'd0, q_fwd2}, 32'd0);
    check("t4_fwd_data", q_fwd_data, 32'hCAFE_0007);
`else
    check("t4_busy_T4", {31'd0, q_busy1}, 32'd1);
`endif
    next_cycle();
    @(negedge clk);
    check("t4_busy_T5", {31'd0, q_busy1}, 32'd0);

    // 5: set and clear of x8 on the same edge -> stays busy
    do_reset();
    rsv_valid = 1'b1; rsv_addr = 5'd8; q_addr1 = 5'd8;
    next_cycle();
    rsv_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd8; req0_data = 32'h0000_0808;
    @(negedge clk);
    check("t5_ready0", {31'd0, req0_ready}, 32'd1);
    push_exp(5'd8, 32'h0000_0808);
    next_cycle();
    req0_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 5'd8;
    @(negedge clk);
    check("t5_wen", {31'd0, rf_wen}, 32'd1);
    next_cycle();
    rsv_valid = 1'b0;
    @(negedge clk);
    check("t5_busy_set_wins", {31'd0, q_busy1}, 32'd1);

    // 6: reset in the cycle after a handshake drops the write and all reservations
    do_reset();
    rsv_valid = 1'b1; rsv_addr = 5'd3; q_addr1 = 5'd3;
    next_cycle();
    rsv_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_0066;
    @(negedge clk);
    check("t6_ready0", {31'd0, req0_ready}, 32'd1);
    check("t6_busy_pre", {31'd0, q_busy1}, 32'd1);
    next_cycle();
    req0_valid = 1'b0;
    check("t6_wen_pre", {31'd0, rf_wen}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_wen_async", {31'd0, rf_wen}, 32'd0);
    check("t6_busy_async", {31'd0, q_busy1}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd20; req0_data = 32'h0000_0020;
    req1_valid = 1'b1; req1_addr = 5'd21; req1_data = 32'h0000_0021;
    @(negedge clk);
    check("t6_prio_ready0", {31'd0, req0_ready}, 32'd1);
    check("t6_prio_ready1", {31'd0, req1_ready}, 32'd0);
    push_exp(5'd20, 32'h0000_0020);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    check("t6_next_ready1", {31'd0, req1_ready}, 32'd1);
    push_exp(5'd21, 32'h0000_0021);
    next_cycle();
    req1_valid = 1'b0;
    next_cycle();
    next_cycle();
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
